// File: rtl/led_timing_pkg.sv
// Shared types and default timing constants for the LED strip timing generator.
package led_timing_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LATCH  = 2'd2
    } led_state_t;

    // Index width that stays legal (at least one bit) for degenerate counts of 0 or 1.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_SEGMENT_DIV      = 5;
    localparam int DEFAULT_SEGMENTS_PER_BIT = 3;
    localparam int DEFAULT_BITS_PER_LED     = 24;
    localparam int DEFAULT_MAX_LEDS         = 256;
    localparam int DEFAULT_LATCH_MIN_CYCLES = 600;
    localparam int DEFAULT_FRAME_WIDTH      = 20;

    localparam int DEFAULT_SEGMENT_INDEX_W = idx_width(DEFAULT_SEGMENTS_PER_BIT);
    localparam int DEFAULT_BIT_INDEX_W     = idx_width(DEFAULT_BITS_PER_LED);
    localparam int DEFAULT_LED_INDEX_W     = idx_width(DEFAULT_MAX_LEDS);
    localparam int DEFAULT_LED_COUNT_W     = idx_width(DEFAULT_MAX_LEDS + 1);

endpackage

// File: rtl/led_timing_generator_strobe_prescaler.sv
// Wrapping counter with a terminal-count strobe; chained to build segment, bit and LED timing.
module strobe_prescaler
    import led_timing_pkg::*;
#(
    parameter int WIDTH = 3
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             tick
);

    assign tick = advance && (count == terminal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_timing_generator.sv
// Frame sequencer for an LED strip: single-cycle timing strobes, position indices and latch gap.
module led_timing_generator
    import led_timing_pkg::*;
#(
    parameter int SEGMENT_DIV      = DEFAULT_SEGMENT_DIV,
    parameter int SEGMENTS_PER_BIT = DEFAULT_SEGMENTS_PER_BIT,
    parameter int BITS_PER_LED     = DEFAULT_BITS_PER_LED,
    parameter int MAX_LEDS         = DEFAULT_MAX_LEDS,
    parameter int LATCH_MIN_CYCLES = DEFAULT_LATCH_MIN_CYCLES,
    parameter int FRAME_WIDTH      = DEFAULT_FRAME_WIDTH
)(
    input  logic                                   clock_12mhz,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   restart,
    input  logic [idx_width(MAX_LEDS + 1)-1:0]     led_count,
    input  logic [FRAME_WIDTH-1:0]                 frame_period,
    output logic                                   frame_strobe,
    output logic                                   segment_strobe,
    output logic                                   bit_strobe,
    output logic                                   led_strobe,
    output logic [idx_width(SEGMENTS_PER_BIT)-1:0] segment_index,
    output logic [idx_width(BITS_PER_LED)-1:0]     bit_index,
    output logic [idx_width(MAX_LEDS)-1:0]         led_index,
    output logic                                   active,
    output logic                                   latch,
    output logic                                   overrun
);

    localparam int PRE_W   = idx_width(SEGMENT_DIV);
    localparam int SEG_W   = idx_width(SEGMENTS_PER_BIT);
    localparam int BIT_W   = idx_width(BITS_PER_LED);
    localparam int LED_W   = idx_width(MAX_LEDS);
    localparam int LATCH_W = idx_width(LATCH_MIN_CYCLES);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(SEGMENT_DIV - 1);
    localparam logic [SEG_W-1:0]   SEG_LAST   = SEG_W'(SEGMENTS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS_PER_LED - 1);
    localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_MIN_CYCLES - 1);

    led_state_t             state_q;
    led_state_t             state_d;
    logic [FRAME_WIDTH-1:0] frame_cnt_q;
    logic [FRAME_WIDTH-1:0] target_q;
    logic [LATCH_W-1:0]     latch_cnt_q;
    logic [LED_W-1:0]       last_led_q;
    logic                   frame_strobe_q;
    logic                   overrun_q;

    logic                   run;
    logic                   abort;
    logic                   start;
    logic                   frame_done;
    logic                   count_clear;
    logic                   last_led;
    logic [PRE_W-1:0]       unused_prescale;

    assign run         = (state_q == ACTIVE);
    assign abort       = restart && (state_q != IDLE);
    assign count_clear = abort || !run;
    assign frame_done  = (state_q == LATCH)
                      && (frame_cnt_q >= target_q)
                      && (latch_cnt_q >= LATCH_LAST);

    // Clock prescaler -> segment -> bit -> LED; each level advances on the tick of the one below.
    strobe_prescaler #(.WIDTH(PRE_W)) u_prescale (
        .clk      (clock_12mhz),
        .rst_n    (reset),
        .clear    (count_clear),
        .advance  (run),
        .terminal (PRE_LAST),
        .count    (unused_prescale),
        .tick     (segment_strobe)
    );

    strobe_prescaler #(.WIDTH(SEG_W)) u_segment (
        .clk      (clock_12mhz),
        .rst_n    (reset),
        .clear    (count_clear),
        .advance  (segment_strobe),
        .terminal (SEG_LAST),
        .count    (segment_index),
        .tick     (bit_strobe)
    );

    strobe_prescaler #(.WIDTH(BIT_W)) u_bit (
        .clk      (clock_12mhz),
        .rst_n    (reset),
        .clear    (count_clear),
        .advance  (bit_strobe),
        .terminal (BIT_LAST),
        .count    (bit_index),
        .tick     (led_strobe)
    );

    strobe_prescaler #(.WIDTH(LED_W)) u_led (
        .clk      (clock_12mhz),
        .rst_n    (reset),
        .clear    (count_clear),
        .advance  (led_strobe),
        .terminal (last_led_q),
        .count    (led_index),
        .tick     (last_led)
    );

    // Restart outranks both the last-LED exit and a coincident frame end.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                start = enable;
            end
            ACTIVE: begin
                if (abort || last_led) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (!abort && frame_done) begin
                    start = enable;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start) begin
            state_d = (led_count == '0) ? LATCH : ACTIVE;
        end
    end

    always_ff @(posedge clock_12mhz or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            frame_strobe_q <= 1'b0;
            overrun_q      <= 1'b0;
            frame_cnt_q    <= '0;
            latch_cnt_q    <= '0;
            target_q       <= '0;
            last_led_q     <= '0;
        end else begin
            state_q        <= state_d;
            frame_strobe_q <= start;

            if (start) begin
                last_led_q <= LED_W'(led_count - 1'b1);
                target_q   <= (frame_period == '0) ? '0 : frame_period - 1'b1;
            end

            if (start || abort || (state_d == IDLE)) begin
                frame_cnt_q <= '0;
            end else if (frame_cnt_q != '1) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end

            if ((state_q == LATCH) && (state_d == LATCH) && !abort && !start) begin
                if (latch_cnt_q != LATCH_LAST) begin
                    latch_cnt_q <= latch_cnt_q + 1'b1;
                end
            end else begin
                latch_cnt_q <= '0;
            end

            if (frame_done && !abort && (frame_cnt_q > target_q)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign frame_strobe = frame_strobe_q;
    assign active       = run;
    assign latch        = (state_q == LATCH);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_led_timing_generator.sv
// Scoreboard bench for led_timing_generator: a frame-time arithmetic model predicts every clock.
module tb_led_timing_generator;

    localparam int SD       = 5;
    localparam int SPB      = 3;
    localparam int BPL      = 24;
    localparam int LMIN     = 600;
    localparam int BIT_CLKS = SD * SPB;
    localparam int LED_CLKS = BIT_CLKS * BPL;

    logic        clock_12mhz = 1'b0;
    logic        reset;
    logic        enable;
    logic        restart;
    logic [8:0]  led_count;
    logic [19:0] frame_period;
    logic        frame_strobe;
    logic        segment_strobe;
    logic        bit_strobe;
    logic        led_strobe;
    logic [1:0]  segment_index;
    logic [4:0]  bit_index;
    logic [7:0]  led_index;
    logic        active;
    logic        latch;
    logic        overrun;

    typedef struct packed {
        logic       frame_strobe;
        logic       segment_strobe;
        logic       bit_strobe;
        logic       led_strobe;
        logic [1:0] segment_index;
        logic [4:0] bit_index;
        logic [7:0] led_index;
        logic       active;
        logic       latch;
        logic       overrun;
    } obs_t;

    obs_t exp_q[$];
    int   cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: time since frame start (or since restart) plus the sampled frame settings.
    bit m_in_frame;
    bit m_aborted;
    bit m_ovr;
    int m_t;
    int m_n;
    int m_tgt;

    led_timing_generator dut (
        .clock_12mhz    (clock_12mhz),
        .reset          (reset),
        .enable         (enable),
        .restart        (restart),
        .led_count      (led_count),
        .frame_period   (frame_period),
        .frame_strobe   (frame_strobe),
        .segment_strobe (segment_strobe),
        .bit_strobe     (bit_strobe),
        .led_strobe     (led_strobe),
        .segment_index  (segment_index),
        .bit_index      (bit_index),
        .led_index      (led_index),
        .active         (active),
        .latch          (latch),
        .overrun        (overrun)
    );

    always #5 clock_12mhz = ~clock_12mhz;

    function automatic int active_len();
        return m_aborted ? 0 : m_n * LED_CLKS;
    endfunction

    function automatic bit model_frame_end();
        int a_len = active_len();
        return m_in_frame && (m_t >= a_len) && (m_t >= m_tgt) && ((m_t - a_len) >= LMIN - 1);
    endfunction

    function automatic obs_t model_outputs();
        obs_t o     = '0;
        int   a_len = active_len();
        o.overrun = m_ovr;
        if (m_in_frame) begin
            o.frame_strobe = (m_t == 0) && !m_aborted;
            if (m_t < a_len) begin
                o.active         = 1'b1;
                o.segment_strobe = (m_t % SD) == SD - 1;
                o.bit_strobe     = (m_t % BIT_CLKS) == BIT_CLKS - 1;
                o.led_strobe     = (m_t % LED_CLKS) == LED_CLKS - 1;
                o.segment_index  = 2'((m_t / SD) % SPB);
                o.bit_index      = 5'((m_t / BIT_CLKS) % BPL);
                o.led_index      = 8'(m_t / LED_CLKS);
            end else begin
                o.latch = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_aborted  = 1'b0;
        m_ovr      = 1'b0;
        m_t        = 0;
        m_n        = 0;
        m_tgt      = 0;
    endtask

    task automatic model_start(input int n, input int p);
        m_in_frame = 1'b1;
        m_aborted  = 1'b0;
        m_t        = 0;
        m_n        = n;
        m_tgt      = (p <= 1) ? 0 : p - 1;
    endtask

    task automatic model_step(input logic en, input logic rs, input int n, input int p);
        if (!m_in_frame) begin
            if (en) model_start(n, p);
        end else if (rs) begin
            m_t       = 0;
            m_aborted = 1'b1;
        end else if (model_frame_end()) begin
            if (m_t > m_tgt) m_ovr = 1'b1;
            if (en) model_start(n, p);
            else m_in_frame = 1'b0;
        end else begin
            m_t++;
        end
    endtask

    // One clock: predict this clock's outputs, drive inputs, then advance the model across the edge.
    task automatic applyStimulus(input logic rst_v, input logic en, input logic rs,
                                 input int n, input int p);
        @(posedge clock_12mhz);
        #1;
        if (!rst_v) model_reset();
        exp_q.push_back(model_outputs());
        cyc_q.push_back(cycle);
        reset        = rst_v;
        enable       = en;
        restart      = rs;
        led_count    = 9'(n);
        frame_period = 20'(p);
        if (rst_v) model_step(en, rs, n, p);
        cycle++;
    endtask

    task automatic run_cycles(input int count, input logic en, input int n, input int p);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, en, 1'b0, n, p);
        end
    endtask

    function automatic string fmt(input obs_t o);
        return $sformatf("fs=%b ss=%b bs=%b ls=%b seg=%0d bit=%0d led=%0d act=%b lat=%b ovr=%b",
                         o.frame_strobe, o.segment_strobe, o.bit_strobe, o.led_strobe,
                         o.segment_index, o.bit_index, o.led_index, o.active, o.latch, o.overrun);
    endfunction

    task automatic checkOutput(input obs_t expected, input int cyc);
        obs_t actual;
        actual = {frame_strobe, segment_strobe, bit_strobe, led_strobe, segment_index,
                  bit_index, led_index, active, latch, overrun};
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL outputs at cycle %0d: got {%s} expected {%s}",
                     cyc, fmt(actual), fmt(expected));
        end
    endtask

    always @(negedge clock_12mhz) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front(), cyc_q.pop_front());
        end
    end

    initial begin
        logic en_r;
        reset        = 1'b0;
        enable       = 1'b0;
        restart      = 1'b0;
        led_count    = '0;
        frame_period = '0;
        model_reset();

        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);

        $display("[TB] two LEDs, period 2000");
        run_cycles(4100, 1'b1, 2, 2000);
        $display("[TB] two LEDs, period 800 (overrun)");
        run_cycles(3000, 1'b1, 2, 800);
        $display("[TB] zero LEDs, period 1000");
        run_cycles(3000, 1'b1, 0, 1000);
        run_cycles(1500, 1'b0, 0, 1000);

        $display("[TB] restart at clock 100");
        run_cycles(1, 1'b1, 2, 2000);
        run_cycles(100, 1'b1, 2, 2000);
        applyStimulus(1'b1, 1'b1, 1'b1, 2, 2000);
        run_cycles(2200, 1'b1, 2, 2000);
        run_cycles(2100, 1'b0, 2, 2000);

        $display("[TB] enable dropped at clock 50");
        run_cycles(1, 1'b1, 2, 2000);
        run_cycles(50, 1'b1, 2, 2000);
        run_cycles(2100, 1'b0, 2, 2000);

        $display("[TB] restart while idle, then reset at clock 300");
        applyStimulus(1'b1, 1'b0, 1'b1, 2, 2000);
        run_cycles(1, 1'b1, 2, 2000);
        run_cycles(300, 1'b1, 2, 2000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2, 2000);
        run_cycles(5, 1'b0, 2, 2000);
        run_cycles(800, 1'b1, 2, 2000);

        $display("[TB] minimum frames with period 1 and 0");
        run_cycles(2000, 1'b1, 1, 1);
        run_cycles(1500, 1'b1, 0, 0);

        $display("[TB] randomized inputs");
        en_r = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 1499) == 0) en_r = ~en_r;
            applyStimulus(1'b1, en_r, ($urandom_range(0, 699) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3000)));
        end

        @(negedge clock_12mhz);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_timing_generator.md
Name: led_timing_generator

Overview:
Parametrised successor to the fixed clock_generator. Derives every LED-strip timing reference from the one system clock as single-cycle enable strobes, not divided clocks. Adds runtime LED count, a programmable frame period, an enforced latch (reset) gap, position indices, and enable/restart control. Drives the bit serializer and the frame-buffer reader of the LED actor.

Parameters:
SEGMENT_DIV, 5, system clocks per bit segment (12 MHz / 5 = 2.4 MHz)
SEGMENTS_PER_BIT, 3, segments per encoded bit
BITS_PER_LED, 24, bits per LED (GRB)
MAX_LEDS, 256, largest supported led_count
LATCH_MIN_CYCLES, 600, minimum low gap between frames (50 us at 12 MHz)
FRAME_WIDTH, 20, width of the frame_period input and the frame counter

Ports:
clock_12mhz  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  run frames continuously while high
restart  in  1  synchronous single-cycle abort of the current frame
led_count  in  clog2(MAX_LEDS+1)  LEDs per frame; sampled at frame start
frame_period  in  FRAME_WIDTH  frame length in clocks; sampled at frame start
frame_strobe  out  1  high in the first clock of each frame
segment_strobe  out  1  high in the last clock of each segment (ACTIVE only)
bit_strobe  out  1  high in the last clock of each bit
led_strobe  out  1  high in the last clock of each LED
segment_index  out  clog2(SEGMENTS_PER_BIT)  current segment
bit_index  out  clog2(BITS_PER_LED)  current bit, 0 = MSB sent first
led_index  out  clog2(MAX_LEDS)  current LED
active  out  1  data phase in progress
latch  out  1  latch gap in progress
overrun  out  1  sticky: a requested period was shorter than active time + LATCH_MIN_CYCLES

Behaviour:
- While reset is low: all outputs 0, all counters 0, state IDLE.
- States:
  - IDLE: waits for enable.
  - ACTIVE: data phase.
  - LATCH: gap between frames.
- IDLE with enable=1: the next clock is a frame start.
- Every frame start:
  - frame_strobe=1 for that clock.
  - led_count and frame_period latched into internal registers.
  - frame counter, prescaler and indices all 0.
  - Enter ACTIVE, or LATCH directly if led_count=0.
- ACTIVE:
  - Prescaler counts 0..SEGMENT_DIV-1; segment_strobe when prescaler = SEGMENT_DIV-1.
  - segment_index advances on segment_strobe and wraps at SEGMENTS_PER_BIT-1; bit_strobe is segment_strobe with the last segment.
  - bit_index wraps at BITS_PER_LED-1; led_strobe is bit_strobe with the last bit.
  - led_strobe with led_index = latched count-1: the next clock enters LATCH.
  - Each LED takes 360 clocks at the default parameters.
- LATCH:
  - Strobes are 0; indices hold 0.
  - The latch counter counts clocks spent in LATCH.
  - Frame ends when frame counter ≥ latched period-1 AND latch counter ≥ LATCH_MIN_CYCLES-1.
  - The next clock is a frame start if enable=1, otherwise IDLE.
- overrun is set in the frame-end clock if the frame counter exceeded latched period-1. It is cleared only by reset.
- enable going low mid-frame: the frame completes normally, then IDLE.
- restart=1 in any state except IDLE:
  - The next clock is LATCH with the frame counter and latch counter at 0.
  - No strobes are asserted in the restart clock.
  - The frame ends per the normal LATCH rule, measured from the restart.
- restart has priority over a coincident frame end or led_strobe.
- restart in IDLE is ignored.
- frame_period=0 or 1 behaves as the minimum possible frame.
- The frame counter saturates; it never wraps.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package led_timing_pkg: state enum (IDLE, ACTIVE, LATCH), default timing constants, and the derived index widths.
- One natural sub-module, strobe_prescaler: a counter with a terminal-count strobe and clear. It is instantiated for the segment, bit and LED levels.

Test Plan:
- led_count=2, period=2000, enable=1 after reset:
  - frame_strobe at clock 0.
  - segment_strobe at 4, 9, 14 …; bit_strobe at 14.
  - led_strobe at 359 and 719.
  - active=1 over 0..719, latch=1 over 720..1999.
  - Next frame_strobe at 2000.
- led_count=2, period=800:
  - Frame length is 1320 (720 + 600).
  - overrun=1 from the frame end onward.
- led_count=0, period=1000:
  - active is never 1; latch over 0..999.
  - frame_strobe every 1000 clocks.
- restart pulsed at clock 100 of the test-1 setup:
  - Clock 101: active=0, latch=1, no strobes.
  - Next frame_strobe at clock 2101.
- enable dropped at clock 50 of the test-1 setup:
  - The frame runs to clock 1999, then IDLE; no frame_strobe at 2000.
- reset asserted at clock 300:
  - All outputs 0 immediately, before the next clock edge.
  - After release, the first frame_strobe comes one clock after enable is sampled high.
